// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: parses framed UART read/write commands, runs the memory-map handshake and queues a status response
module uart_cmd_engine #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 2,
  parameter logic [7:0] START_BYTE = 8'h01,
  parameter logic [7:0] READ_CMD = 8'h02,
  parameter logic [7:0] WRITE_CMD = 8'h03,
  parameter int RX_TIMEOUT = 2_100_000,
  parameter int MEM_TIMEOUT = 1024,
  localparam int AW = 8 * ADDR_BYTES,
  localparam int DW = 8 * DATA_BYTES
) (
  input  logic          clk210_p,
  input  logic          reset_p,
  input  logic          fifo_rx_empty_p,
  input  logic [7:0]    fifo_rx_dout_p,
  output logic          fifo_rx_rd_en_p,
  input  logic          fifo_tx_full_p,
  output logic [7:0]    fifo_tx_din_p,
  output logic          fifo_tx_wr_en_p,
  output logic          transmit_req_p,
  input  logic          transmit_done_p,
  output logic [AW-1:0] memory_map_adrs_p,
  output logic [DW-1:0] memory_map_wr_data_p,
  input  logic [DW-1:0] memory_map_rd_data_p,
  output logic          memory_map_rd_req_p,
  output logic          memory_map_wr_req_p,
  input  logic          memory_map_rd_ack_p,
  input  logic          memory_map_wr_ack_p,
  input  logic          memory_map_er_p,
  output logic [7:0]    frame_err_count_p,
  output logic          busy_p
);
  localparam int BW = $clog2((ADDR_BYTES > DATA_BYTES ? ADDR_BYTES : DATA_BYTES) + 1);
  localparam int RTW = $clog2(RX_TIMEOUT + 1);
  localparam int MTW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, MEM_REQ, MEM_WAIT, LOAD_TX, TX_START, TX_WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic rd_en_q, rd_en_d, wr_en_q, wr_en_d, treq_q, treq_d, rreq_q, rreq_d, wreq_q, wreq_d, is_rd_q, is_rd_d;
  logic [7:0] din_q, din_d, cnt_q, cnt_d, status_q, status_d, tx_idx_q, tx_idx_d;
  logic [AW-1:0] adrs_q, adrs_d;
  logic [DW-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [RTW-1:0] rt_q, rt_d;
  logic [MTW-1:0] mt_q, mt_d;
  logic cap, ack, go;
  logic [7:0] last_idx, cnt_sat;
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    treq_d = treq_q;
    rreq_d = rreq_q;
    wreq_d = wreq_q;
    is_rd_d = is_rd_q;
    din_d = din_q;
    cnt_d = cnt_q;
    status_d = status_q;
    tx_idx_d = tx_idx_q;
    adrs_d = adrs_q;
    wdat_d = wdat_q;
    rdat_d = rdat_q;
    bc_d = bc_q;
    rt_d = rt_q;
    mt_d = mt_q;
    go = 1'b0;
    cap = ph_q == 2'd3;
    ack = is_rd_q ? memory_map_rd_ack_p : memory_map_wr_ack_p;
    last_idx = is_rd_q ? 8'(DATA_BYTES + 1) : 8'd1;
    cnt_sat = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    // Byte fetch: rd_en pulse, one wait cycle, then capture on phase 3
    if (state_q inside {IDLE, GET_CMD, GET_ADDR, GET_DATA}) begin
      rd_en_d = ph_q == 2'd0 && !fifo_rx_empty_p;
      ph_d = (ph_q != 2'd0 || rd_en_d) ? ph_q + 2'd1 : ph_q;
      rt_d = (state_q == IDLE || cap) ? '0 : rt_q + RTW'(1);
    end
    case (state_q)
      IDLE: if (cap && fifo_rx_dout_p == START_BYTE) state_d = GET_CMD;
      GET_CMD: if (cap) begin
        bc_d = '0;
        tx_idx_d = 8'd0;
        is_rd_d = fifo_rx_dout_p == READ_CMD;
        state_d = (fifo_rx_dout_p == READ_CMD || fifo_rx_dout_p == WRITE_CMD) ? GET_ADDR : LOAD_TX;
        if (fifo_rx_dout_p != READ_CMD && fifo_rx_dout_p != WRITE_CMD) begin
          status_d = 8'h03;
          cnt_d = cnt_sat;
        end
      end
      GET_ADDR: if (cap) begin
        adrs_d = (adrs_q << 8) | AW'(fifo_rx_dout_p);
        bc_d = bc_q + BW'(1);
        if (bc_q == BW'(ADDR_BYTES - 1)) begin
          bc_d = '0;
          go = is_rd_q;
          state_d = GET_DATA;
        end
      end
      GET_DATA: if (cap) begin
        wdat_d = (wdat_q << 8) | DW'(fifo_rx_dout_p);
        bc_d = bc_q + BW'(1);
        go = bc_q == BW'(DATA_BYTES - 1);
      end
      MEM_REQ, MEM_WAIT: begin
        state_d = MEM_WAIT;
        mt_d = mt_q + MTW'(1);
        if (memory_map_er_p || ack || mt_q == MTW'(MEM_TIMEOUT - 1)) begin
          rreq_d = 1'b0;
          wreq_d = 1'b0;
          tx_idx_d = 8'd0;
          state_d = LOAD_TX;
          status_d = memory_map_er_p ? 8'h01 : ack ? 8'h00 : 8'h02;
          rdat_d = (ack && is_rd_q && !memory_map_er_p) ? memory_map_rd_data_p : '0;
        end
      end
      LOAD_TX: if (!wr_en_q && !fifo_tx_full_p) begin
        wr_en_d = 1'b1;
        din_d = tx_idx_q == 8'd0 ? START_BYTE : tx_idx_q == 8'd1 ? status_q : rdat_q[DW-1 -: 8];
        rdat_d = tx_idx_q >= 8'd2 ? rdat_q << 8 : rdat_q;
        tx_idx_d = tx_idx_q + 8'd1;
        state_d = tx_idx_q == last_idx ? TX_START : LOAD_TX;
      end
      TX_START: begin
        treq_d = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: if (transmit_done_p) begin
        treq_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      rreq_d = is_rd_q;
      wreq_d = !is_rd_q;
      mt_d = '0;
      rdat_d = '0;
      state_d = MEM_REQ;
    end
    // Host went silent mid-frame: drop the partial frame without a response
    if (state_q inside {GET_CMD, GET_ADDR, GET_DATA} && !cap && rt_q == RTW'(RX_TIMEOUT - 1)) begin
      state_d = IDLE;
      ph_d = 2'd0;
      rd_en_d = 1'b0;
      cnt_d = cnt_sat;
    end
  end
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      ph_q <= 2'd0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      treq_q <= 1'b0;
      rreq_q <= 1'b0;
      wreq_q <= 1'b0;
      is_rd_q <= 1'b0;
      din_q <= 8'd0;
      cnt_q <= 8'd0;
      status_q <= 8'd0;
      tx_idx_q <= 8'd0;
      adrs_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      bc_q <= '0;
      rt_q <= '0;
      mt_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      treq_q <= treq_d;
      rreq_q <= rreq_d;
      wreq_q <= wreq_d;
      is_rd_q <= is_rd_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
      status_q <= status_d;
      tx_idx_q <= tx_idx_d;
      adrs_q <= adrs_d;
      wdat_q <= wdat_d;
      rdat_q <= rdat_d;
      bc_q <= bc_d;
      rt_q <= rt_d;
      mt_q <= mt_d;
    end
  end
  assign fifo_rx_rd_en_p = rd_en_q;
  assign fifo_tx_din_p = din_q;
  assign fifo_tx_wr_en_p = wr_en_q;
  assign transmit_req_p = treq_q;
  assign memory_map_adrs_p = adrs_q;
  assign memory_map_wr_data_p = wdat_q;
  assign memory_map_rd_req_p = rreq_q;
  assign memory_map_wr_req_p = wreq_q;
  assign frame_err_count_p = cnt_q;
  assign busy_p = state_q != IDLE;
endmodule
